vga_sync_gen: RTL and testbench



---
 rtl/vga_pkg.sv | 23 ++
 rtl/mod_counter.sv | 40 ++++
 rtl/vga_sync_gen.sv | 104 ++++++++++
 tb/tb_vga_sync_gen.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared VGA timing defaults and window helper
package vga_pkg;

  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam bit SYNC_POL = 1'b0;
  localparam int CNT_W    = 10;

  function automatic logic in_window(input logic [CNT_W-1:0] v, input int lo, input int len);
    return (int'(v) >= lo) && (int'(v) < lo + len);
  endfunction

endpackage

// File: rtl/mod_counter.sv
// rtl/mod_counter.sv - enabled modulo counter exposing current, next and wrap
module mod_counter #(
  parameter int MOD = 2,
  parameter int W   = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en_i,
  output logic [W-1:0] count_o,
  output logic [W-1:0] next_o,
  output logic         wrap_o
);

  localparam logic [W-1:0] LAST = W'(MOD - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    wrap_o  = en_i && (count_q == LAST);
    count_d = count_q;
    if (wrap_o) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign next_o  = count_d;

endmodule

// File: rtl/vga_sync_gen.sv
// rtl/vga_sync_gen.sv - VGA raster timing: pixel enable, x/y counters, syncs, frame tick
module vga_sync_gen #(
  parameter int H_DISPLAY = vga_pkg::H_DISPLAY,
  parameter int H_FRONT   = vga_pkg::H_FRONT,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BACK    = vga_pkg::H_BACK,
  parameter int V_DISPLAY = vga_pkg::V_DISPLAY,
  parameter int V_FRONT   = vga_pkg::V_FRONT,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BACK    = vga_pkg::V_BACK,
  parameter int CLK_DIV   = 4,
  parameter bit SYNC_POL  = vga_pkg::SYNC_POL
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       p_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       frame_tick
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0]       H_DISP_W = 10'(H_DISPLAY);
  localparam logic [9:0]       V_DISP_W = 10'(V_DISPLAY);
  localparam logic [9:0]       TICK_Y   = 10'(V_DISPLAY + 1);

  logic [DIV_W-1:0] div_count_unused;
  logic             div_wrap_unused;
  logic [DIV_W-1:0] div_next;
  logic [9:0]       x_cnt, x_next;
  logic [9:0]       y_cnt, y_next;
  logic             h_wrap;
  logic             v_wrap_unused;

  logic p_tick_q, p_tick_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;
  logic frame_tick_q, frame_tick_d;

  mod_counter #(.MOD(CLK_DIV), .W(DIV_W)) u_div (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (1'b1),
    .count_o (div_count_unused),
    .next_o  (div_next),
    .wrap_o  (div_wrap_unused)
  );

  mod_counter #(.MOD(H_TOTAL), .W(10)) u_hcnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (p_tick_q),
    .count_o (x_cnt),
    .next_o  (x_next),
    .wrap_o  (h_wrap)
  );

  mod_counter #(.MOD(V_TOTAL), .W(10)) u_vcnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en_i    (h_wrap),
    .count_o (y_cnt),
    .next_o  (y_next),
    .wrap_o  (v_wrap_unused)
  );

  // Registered from next-counter values so every output flips on the same edge as x/y.
  always_comb begin
    p_tick_d     = (div_next == DIV_LAST);
    hsync_d      = vga_pkg::in_window(x_next, H_DISPLAY + H_FRONT, H_SYNC) ? SYNC_POL : ~SYNC_POL;
    vsync_d      = vga_pkg::in_window(y_next, V_DISPLAY + V_FRONT, V_SYNC) ? SYNC_POL : ~SYNC_POL;
    frame_tick_d = h_wrap && (y_next == TICK_Y);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_tick_q     <= 1'b0;
      hsync_q      <= ~SYNC_POL;
      vsync_q      <= ~SYNC_POL;
      frame_tick_q <= 1'b0;
    end else begin
      p_tick_q     <= p_tick_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign p_tick     = p_tick_q;
  assign x          = x_cnt;
  assign y          = y_cnt;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign frame_tick = frame_tick_q;
  assign video_on   = (x_cnt < H_DISP_W) && (y_cnt < V_DISP_W);

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb/tb_vga_sync_gen.sv - directed self-checking bench for vga_sync_gen
module tb_vga_sync_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic ra = 1'b0, rb = 1'b0, rc = 1'b0;

  logic       pt_a, hs_a, vs_a, von_a, ft_a;
  logic [9:0] x_a, y_a;
  logic       pt_b, hs_b, vs_b, von_b, ft_b;
  logic [9:0] x_b, y_b;
  logic       pt_c, hs_c, vs_c, von_c, ft_c;
  logic [9:0] x_c, y_c;

  int total = 0;
  int bad   = 0;

  // Default 640x480 timing, divide by 4, active-low syncs
  vga_sync_gen u_a (
    .clk(clk), .reset_n(ra), .p_tick(pt_a), .x(x_a), .y(y_a),
    .hsync(hs_a), .vsync(vs_a), .video_on(von_a), .frame_tick(ft_a)
  );

  // Tiny raster (15 x 10, divide by 4) so whole frames fit in a short run
  vga_sync_gen #(
    .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .CLK_DIV(4), .SYNC_POL(1'b0)
  ) u_b (
    .clk(clk), .reset_n(rb), .p_tick(pt_b), .x(x_b), .y(y_b),
    .hsync(hs_b), .vsync(vs_b), .video_on(von_b), .frame_tick(ft_b)
  );

  // Default timing, pixel clock equals system clock, active-high syncs
  vga_sync_gen #(.CLK_DIV(1), .SYNC_POL(1'b1)) u_c (
    .clk(clk), .reset_n(rc), .p_tick(pt_c), .x(x_c), .y(y_c),
    .hsync(hs_c), .vsync(vs_c), .video_on(von_c), .frame_tick(ft_c)
  );

  task automatic check(input string tag, input int got, input int want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  initial begin
    int px, py, cnt, mn, mx, err, err2, nt, t1, t2, wclk, wx, wy;
    bit done;

    // Reset state on all three instances
    repeat (10) @(negedge clk);
    check("a_rst_x", int'(x_a), 0);
    check("a_rst_y", int'(y_a), 0);
    check("a_rst_hs", int'(hs_a), 1);
    check("a_rst_vs", int'(vs_a), 1);
    check("a_rst_pt", int'(pt_a), 0);
    check("a_rst_ft", int'(ft_a), 0);
    check("a_rst_von", int'(von_a), 1);
    check("b_rst_pt", int'(pt_b), 0);
    check("b_rst_von", int'(von_b), 1);
    check("b_rst_hsvs", int'({hs_b, vs_b}), 3);
    check("c_rst_hs", int'(hs_c), 0);
    check("c_rst_vs", int'(vs_c), 0);
    check("c_rst_pt", int'(pt_c), 0);
    check("c_rst_xy", int'({x_c, y_c}), 0);
    check("c_rst_ft_von", int'({ft_c, von_c}), 1);
    check("b_rst_xy_ft", int'({x_b, y_b, ft_b}), 0);

    // Release: first p_tick seen by the 4th edge, x advances on it
    ra = 1'b1;
    repeat (2) @(negedge clk);
    check("a_pt_clk2", int'(pt_a), 0);
    @(negedge clk);
    check("a_pt_clk3", int'(pt_a), 1);
    check("a_x_clk3", int'(x_a), 0);
    @(negedge clk);
    check("a_x_clk4", int'(x_a), 1);
    check("a_pt_clk4", int'(pt_a), 0);

    // One full line on the default raster
    cnt = 0; mn = 1023; mx = 0; err = 0; done = 0; px = int'(x_a); wx = -1; wy = -1;
    for (int k = 0; k < 4000 && !done; k++) begin
      @(negedge clk);
      if (!hs_a) begin
        cnt++;
        if (int'(x_a) < mn) mn = int'(x_a);
        if (int'(x_a) > mx) mx = int'(x_a);
      end
      if (von_a !== ((int'(x_a) < 640) && (int'(y_a) < 480))) err++;
      if (px == 799 && int'(x_a) != 799) begin
        wx = int'(x_a); wy = int'(y_a); done = 1;
      end
      px = int'(x_a);
    end
    check("line_done", int'(done), 1);
    check("hs_low_clks", cnt, 384);
    check("hs_low_xmin", mn, 656);
    check("hs_low_xmax", mx, 751);
    check("von_err", err, 0);
    check("line_wrap_x", wx, 0);
    check("line_wrap_y", wy, 1);

    // Tiny raster: two frames of vsync, frame_tick and frame wrap
    rb = 1'b1;
    cnt = 0; mn = 1023; mx = 0; nt = 0; t1 = 0; t2 = 0; err = 0; wclk = 0; wx = -1; wy = -1; py = 0;
    for (int k = 1; k <= 1300; k++) begin
      @(negedge clk);
      if (!vs_b) begin
        cnt++;
        if (int'(y_b) < mn) mn = int'(y_b);
        if (int'(y_b) > mx) mx = int'(y_b);
      end
      if (ft_b) begin
        nt++;
        if (int'(x_b) != 0 || int'(y_b) != 7) err++;
        if (nt == 1) t1 = k;
        else if (nt == 2) t2 = k;
      end
      if (py == 9 && int'(y_b) != 9 && wclk == 0) begin
        wclk = k; wx = int'(x_b); wy = int'(y_b);
      end
      py = int'(y_b);
    end
    check("vs_low_clks", cnt, 240);
    check("vs_low_ymin", mn, 7);
    check("vs_low_ymax", mx, 8);
    check("ft_count", nt, 2);
    check("ft_first_clk", t1, 420);
    check("ft_period", t2 - t1, 600);
    check("ft_pos_err", err, 0);
    check("frame_len", wclk, 600);
    check("frame_wrap_x", wx, 0);
    check("frame_wrap_y", wy, 0);

    // Asynchronous reset mid-frame, between clock edges
    done = 0;
    for (int k = 0; k < 700 && !done; k++) begin
      @(negedge clk);
      if (int'(y_b) == 4 && int'(x_b) == 5) done = 1;
    end
    check("midframe_reached", int'(done), 1);
    #2 rb = 1'b0;
    #1;
    check("async_x", int'(x_b), 0);
    check("async_y", int'(y_b), 0);
    check("async_pt", int'(pt_b), 0);
    check("async_hsvs", int'({hs_b, vs_b}), 3);
    check("async_ft", int'(ft_b), 0);
    repeat (3) @(negedge clk);
    rb = 1'b1;
    repeat (3) @(negedge clk);
    check("rerun_pt_clk3", int'(pt_b), 1);
    check("rerun_xy_clk3", int'({x_b, y_b}), 0);
    @(negedge clk);
    check("rerun_x_clk4", int'(x_b), 1);
    repeat (55) @(negedge clk);
    check("rerun_x_clk59", int'(x_b), 14);
    check("rerun_y_clk59", int'(y_b), 0);
    @(negedge clk);
    check("rerun_x_clk60", int'(x_b), 0);
    check("rerun_y_clk60", int'(y_b), 1);

    // CLK_DIV = 1, active-high syncs
    rc = 1'b1;
    @(negedge clk);
    check("c_pt_clk1", int'(pt_c), 1);
    check("c_x_clk1", int'(x_c), 0);
    px = int'(x_c); err = 0; err2 = 0; cnt = 0; mn = 1023; mx = 0;
    for (int k = 0; k < 900; k++) begin
      @(negedge clk);
      if (pt_c !== 1'b1) err++;
      if (int'(x_c) != ((px == 799) ? 0 : px + 1)) err2++;
      if (hs_c) begin
        cnt++;
        if (int'(x_c) < mn) mn = int'(x_c);
        if (int'(x_c) > mx) mx = int'(x_c);
      end
      px = int'(x_c);
    end
    check("c_pt_not_const", err, 0);
    check("c_x_adv_err", err2, 0);
    check("c_hs_high_clks", cnt, 96);
    check("c_hs_xmin", mn, 656);
    check("c_hs_xmax", mx, 751);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
